// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide, behind valid/ready handshakes.
module alu_seq_unit #(
  parameter int ALU_SIZE = 8,
  parameter int SHIFT_W  = $clog2(ALU_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_SIZE-1:0] alu_in_a,
  input  logic [ALU_SIZE-1:0] alu_in_b,
  input  logic [3:0]          alu_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_SIZE-1:0] alu_out,
  output logic [ALU_SIZE-1:0] alu_out_hi,
  output logic                carry_out,
  output logic                overflow,
  output logic                zero,
  output logic                div_by_zero
);
  localparam int N     = ALU_SIZE;
  localparam int CNT_W = $clog2(ALU_SIZE);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR, OP_ROL, OP_ROR,
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR, OP_GT, OP_EQ
  } op_e;

  state_e           state_q;
  logic             in_ready_q, out_valid_q;
  logic [N-1:0]     alu_out_q, alu_out_hi_q;
  logic             carry_q, overflow_q, zero_q, div_by_zero_q;
  logic             is_mul_q;
  logic [N-1:0]     opnd_q;   // multiplicand for mul, divisor for div
  logic [N-1:0]     acc_hi_q, acc_lo_q;
  logic [CNT_W-1:0] cnt_q;

  op_e              op;
  logic [SHIFT_W-1:0] amt;
  logic [N:0]       sum_w, diff_w, mul_sum, div_shift, div_trial;
  logic [N-1:0]     res_d, res_hi_d, step_hi_d, step_lo_d;
  logic             carry_d, overflow_d, dbz_d, is_long;

  assign op  = op_e'(alu_sel);
  assign amt = alu_in_b[SHIFT_W-1:0];

  // Rotate amounts wrap modulo the width so non-power-of-two sizes stay correct.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input logic [SHIFT_W-1:0] s);
    logic [2*N-1:0] dbl;
    dbl = {v, v} << (int'(s) % N);
    return dbl[2*N-1:N];
  endfunction

  function automatic logic [N-1:0] rotr(input logic [N-1:0] v, input logic [SHIFT_W-1:0] s);
    logic [2*N-1:0] dbl;
    dbl = {v, v} >> (int'(s) % N);
    return dbl[N-1:0];
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    sum_w      = {1'b0, alu_in_a} + {1'b0, alu_in_b};
    diff_w     = {1'b0, alu_in_a} - {1'b0, alu_in_b};
    res_d      = '0;
    res_hi_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    dbz_d      = 1'b0;
    is_long    = (op == OP_MUL) || ((op == OP_DIV) && (alu_in_b != '0));
    unique case (op)
      OP_ADD: begin
        res_d      = sum_w[N-1:0];
        carry_d    = sum_w[N];
        overflow_d = (alu_in_a[N-1] == alu_in_b[N-1]) && (sum_w[N-1] != alu_in_a[N-1]);
      end
      OP_SUB: begin
        res_d      = diff_w[N-1:0];
        carry_d    = diff_w[N];
        overflow_d = (alu_in_a[N-1] != alu_in_b[N-1]) && (diff_w[N-1] != alu_in_a[N-1]);
      end
      OP_DIV: begin
        res_d    = '1;
        res_hi_d = alu_in_a;
        dbz_d    = 1'b1;
      end
      OP_SHL:  res_d = alu_in_a << amt;
      OP_SHR:  res_d = alu_in_a >> amt;
      OP_ROL:  res_d = rotl(alu_in_a, amt);
      OP_ROR:  res_d = rotr(alu_in_a, amt);
      OP_AND:  res_d = alu_in_a & alu_in_b;
      OP_OR:   res_d = alu_in_a | alu_in_b;
      OP_XOR:  res_d = alu_in_a ^ alu_in_b;
      OP_NOR:  res_d = ~(alu_in_a | alu_in_b);
      OP_NAND: res_d = ~(alu_in_a & alu_in_b);
      OP_XNOR: res_d = ~(alu_in_a ^ alu_in_b);
      OP_GT:   res_d = {{(N-1){1'b0}}, alu_in_a > alu_in_b};
      OP_EQ:   res_d = {{(N-1){1'b0}}, alu_in_a == alu_in_b};
      default: res_d = '0;
    endcase
  end

  // One mul or div iteration on the {acc_hi, acc_lo} double-width accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[N-1]};
    div_trial = div_shift - {1'b0, opnd_q};
    if (is_mul_q) begin
      step_hi_d = mul_sum[N:1];
      step_lo_d = {mul_sum[0], acc_lo_q[N-1:1]};
    end else if (div_shift >= {1'b0, opnd_q}) begin
      step_hi_d = div_trial[N-1:0];
      step_lo_d = {acc_lo_q[N-2:0], 1'b1};
    end else begin
      step_hi_d = div_shift[N-1:0];
      step_lo_d = {acc_lo_q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      alu_out_q     <= '0;
      alu_out_hi_q  <= '0;
      carry_q       <= 1'b0;
      overflow_q    <= 1'b0;
      zero_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      is_mul_q      <= 1'b0;
      opnd_q        <= '0;
      acc_hi_q      <= '0;
      acc_lo_q      <= '0;
      cnt_q         <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            if (is_long) begin
              state_q  <= EXEC;
              is_mul_q <= (op == OP_MUL);
              opnd_q   <= (op == OP_MUL) ? alu_in_a : alu_in_b;
              acc_hi_q <= '0;
              acc_lo_q <= (op == OP_MUL) ? alu_in_b : alu_in_a;
              cnt_q    <= '0;
            end else begin
              state_q       <= DONE;
              out_valid_q   <= 1'b1;
              alu_out_q     <= res_d;
              alu_out_hi_q  <= res_hi_d;
              carry_q       <= carry_d;
              overflow_q    <= overflow_d;
              zero_q        <= (res_d == '0);
              div_by_zero_q <= dbz_d;
            end
          end
        end
        EXEC: begin
          acc_hi_q <= step_hi_d;
          acc_lo_q <= step_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(N-1)) begin
            state_q       <= DONE;
            out_valid_q   <= 1'b1;
            alu_out_q     <= step_lo_d;
            alu_out_hi_q  <= step_hi_d;
            carry_q       <= 1'b0;
            overflow_q    <= 1'b0;
            zero_q        <= (step_lo_d == '0);
            div_by_zero_q <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign alu_out     = alu_out_q;
  assign alu_out_hi  = alu_out_hi_q;
  assign carry_out   = carry_q;
  assign overflow    = overflow_q;
  assign zero        = zero_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_seq_unit;
  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] alu_in_a = '0;
  logic [7:0] alu_in_b = '0;
  logic [3:0] alu_sel = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] alu_out, alu_out_hi;
  logic       carry_out, overflow, zero, div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       c;
    logic       v;
    logic       z;
    logic       d;
    int         lat;
  } exp_t;

  exp_t cur;

  alu_seq_unit #(.ALU_SIZE(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_sel(alu_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ia, ib, sa, sb, r, k, kr;
    ia = int'(a);
    ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    k  = ib % 8;
    kr = k % N;
    e = '{lo: 8'h00, hi: 8'h00, c: 1'b0, v: 1'b0, z: 1'b0, d: 1'b0, lat: 1};
    case (op)
      4'd0:  begin r = ia + ib; e.lo = 8'(r); e.c = (r > 255); e.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      4'd1:  begin r = ia - ib; e.lo = 8'(r); e.c = (ia < ib); e.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      4'd2:  begin r = ia * ib; e.lo = 8'(r); e.hi = 8'(r / 256); e.lat = N + 1; end
      4'd3:  begin
        if (ib == 0) begin e.lo = 8'hFF; e.hi = a; e.d = 1'b1; end
        else begin e.lo = 8'(ia / ib); e.hi = 8'(ia % ib); e.lat = N + 1; end
      end
      4'd4:  e.lo = 8'(ia << k);
      4'd5:  e.lo = 8'(ia >> k);
      4'd6:  e.lo = 8'((ia << kr) | (ia >> (N - kr)));
      4'd7:  e.lo = 8'((ia >> kr) | (ia << (N - kr)));
      4'd8:  e.lo = a & b;
      4'd9:  e.lo = a | b;
      4'd10: e.lo = a ^ b;
      4'd11: e.lo = ~(a | b);
      4'd12: e.lo = ~(a & b);
      4'd13: e.lo = ~(a ^ b);
      4'd14: e.lo = (ia > ib) ? 8'd1 : 8'd0;
      default: e.lo = (ia == ib) ? 8'd1 : 8'd0;
    endcase
    e.z = (e.lo == 8'h00);
    return e;
  endfunction

  // Accept one op, then wait (bounded) for out_valid and check the latency.
  task automatic start_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int waited, lat;
    bit ready_seen;
    cur = model(op, a, b);
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    alu_in_a = a;
    alu_in_b = b;
    alu_sel  = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_in_a = 8'($urandom);
    alu_in_b = 8'($urandom);
    alu_sel  = 4'($urandom);
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    if (in_ready) ready_seen = 1'b1;
    check("in_ready_low_while_busy", 32'(ready_seen), 32'd0);
    check("latency", 32'(lat), 32'(cur.lat));
  endtask

  task automatic check_result(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_alu_out"}, 32'(alu_out), 32'(cur.lo));
    check({tag, "_alu_out_hi"}, 32'(alu_out_hi), 32'(cur.hi));
    check({tag, "_carry"}, 32'(carry_out), 32'(cur.c));
    check({tag, "_overflow"}, 32'(overflow), 32'(cur.v));
    check({tag, "_zero"}, 32'(zero), 32'(cur.z));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(cur.d));
  endtask

  task automatic finish_op();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    check("in_ready_after_handshake", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    start_op(op, a, b);
    check_result(tag);
    finish_op();
  endtask

  initial begin
    bit seen;

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_out", 32'(alu_out), 32'd0);
    check("rst_flags", {28'd0, carry_out, overflow, zero, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_first_clock_after_release", 32'(in_ready), 32'd1);

    // Directed cases, with the headline values also checked as constants.
    run_op("add_ff_01", 4'd0, 8'hFF, 8'h01);
    check("tp_add_out", 32'(alu_out), 32'h00);
    check("tp_add_carry", 32'(carry_out), 32'd1);
    check("tp_add_zero", 32'(zero), 32'd1);
    run_op("sub_80_01", 4'd1, 8'h80, 8'h01);
    check("tp_sub_out", 32'(alu_out), 32'h7F);
    check("tp_sub_ovf", 32'(overflow), 32'd1);
    run_op("sub_10_20", 4'd1, 8'h10, 8'h20);
    check("tp_sub_borrow", {alu_out, 7'd0, carry_out}, {8'hF0, 8'h01});
    run_op("mul_ff_ff", 4'd2, 8'hFF, 8'hFF);
    check("tp_mul", {alu_out_hi, alu_out}, 32'hFE01);
    run_op("div_200_7", 4'd3, 8'd200, 8'd7);
    check("tp_div", {alu_out_hi, alu_out}, 32'h041C);
    run_op("div_by_zero", 4'd3, 8'h55, 8'h00);
    check("tp_dbz", {alu_out_hi, alu_out}, 32'h55FF);
    run_op("rol", 4'd6, 8'h81, 8'd3);
    check("tp_rol", 32'(alu_out), 32'h0C);
    run_op("ror", 4'd7, 8'h81, 8'd1);
    check("tp_ror", 32'(alu_out), 32'hC0);
    run_op("shl_amt0", 4'd4, 8'h81, 8'd8);
    check("tp_shl0", 32'(alu_out), 32'h81);
    run_op("gt", 4'd14, 8'h80, 8'h7F);
    check("tp_gt", 32'(alu_out), 32'h01);

    // out_ready held high during EXEC must not disturb the multiply.
    @(negedge clk);
    out_ready = 1'b1;
    start_op(4'd2, 8'h9D, 8'h37);
    check_result("mul_out_ready_early");
    finish_op();

    // Backpressure: result held, no accept while out_ready stays low.
    start_op(4'd0, 8'h12, 8'h34);
    check_result("bp_add");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      alu_in_a = 8'($urandom);
      alu_in_b = 8'($urandom);
      alu_sel  = 4'($urandom);
      @(posedge clk);
      #1;
      check("bp_alu_out_stable", {alu_out_hi, alu_out}, {16'd0, cur.hi, cur.lo});
      check("bp_held", {out_valid, in_ready}, 32'b10);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op();
    run_op("after_bp_xor", 4'd10, 8'hF0, 8'h0F);

    // Reset during the 4th EXEC cycle of a divide.
    @(negedge clk);
    alu_in_a = 8'd200;
    alu_in_b = 8'd7;
    alu_sel  = 4'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midexec_rst_outputs", {alu_out_hi, alu_out}, 32'd0);
    check("midexec_rst_ctrl", {out_valid, in_ready, carry_out, overflow, zero, div_by_zero}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_midexec_rst", 32'(in_ready), 32'd1);
    run_op("add_after_rst", 4'd0, 8'h03, 8'h04);
    check("tp_add_after_rst", {alu_out_hi, alu_out}, 32'h0007);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_div_result", 32'(seen), 32'd0);

    // Randomized ops against the model, with random consumer stalls.
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [7:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if (op == 4'd3 && $urandom_range(0, 3) == 0) b = 8'h00;
      start_op(op, a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      check_result("rand");
      finish_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Multi-cycle, parametrised ALU for the MIPS processor datapath. It extends the single-cycle ALU operation set with:
- variable shift/rotate amounts
- full-width multiply (high and low halves)
- iterative divide with remainder and divide-by-zero detection
- zero/carry/overflow flags
- valid/ready handshakes on input and output

It sits between the register-read stage and writeback, and holds one operation in flight at a time.

## Interface
- ALU_SIZE, 8: operand/result width in bits; must be ≥ 4.
- SHIFT_W, $clog2(ALU_SIZE): width of the shift/rotate amount taken from alu_in_b.

- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept an operation
- alu_in_a  input  ALU_SIZE  operand A
- alu_in_b  input  ALU_SIZE  operand B
- alu_sel  input  4  operation select
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- alu_out  output  ALU_SIZE  result; product low half; quotient
- alu_out_hi  output  ALU_SIZE  product high half; remainder; 0 for other ops
- carry_out  output  1  add carry-out / subtract borrow; 0 for other ops
- overflow  output  1  signed add/sub overflow; 0 for other ops
- zero  output  1  alu_out == 0
- div_by_zero  output  1  divide with B == 0

## Operation
- Opcodes, all unsigned unless noted:
  - 0000 add
  - 0001 sub
  - 0010 mul
  - 0011 div
  - 0100 shl by B[SHIFT_W-1:0]
  - 0101 shr by B[SHIFT_W-1:0]
  - 0110 rol by B[SHIFT_W-1:0]
  - 0111 ror by B[SHIFT_W-1:0]
  - 1000 and
  - 1001 or
  - 1010 xor
  - 1011 nor
  - 1100 nand
  - 1101 xnor
  - 1110 A>B → 1, else 0
  - 1111 A==B → 1, else 0
- Operands and alu_sel are captured on accept (in_valid && in_ready). Later input changes are ignored until the next accept.
- States:
  - IDLE: in_ready=1.
  - EXEC: mul/div iterations.
  - DONE: out_valid=1.
- Transitions:
  - IDLE→DONE: accept of any op other than mul, or div with B≠0.
  - IDLE→EXEC: accept of mul, or div with B≠0.
  - EXEC→DONE: after exactly ALU_SIZE iterations, counted by an internal counter.
  - DONE→IDLE: on out_ready.
- Multiply: radix-2 shift-add, 2·ALU_SIZE-bit product. {alu_out_hi, alu_out} = A·B.
- Divide: restoring, one quotient bit per cycle. alu_out = A/B, alu_out_hi = A%B.
- Divide by zero: no iterations. alu_out = all ones, alu_out_hi = A, div_by_zero = 1.
- Subtract: carry_out = 1 when A < B (borrow).
- Overflow:
  - add: operand signs equal and result sign differs.
  - sub: operand signs differ and result sign differs from A.
- Shift/rotate amount 0 returns A unchanged.
- Result outputs and flags are registered. They are held stable for the whole DONE state. They keep their last values in IDLE/EXEC (undefined before the first op, 0 after reset).
- Reset:
  - All outputs 0 and state IDLE, asynchronously.
  - in_ready is 0 while rst is high and 1 from the first clock after release.
  - Reset mid-EXEC or mid-DONE aborts the operation; no result is produced.

## Timing
- Latencies, counted in edges from the accept edge to out_valid high:
  - single-cycle ops and divide-by-zero: 1.
  - mul/div: ALU_SIZE+1.
- in_ready is low from the accept edge until the edge that completes the DONE→IDLE handshake.
- No accept is possible in the same cycle as a result handshake. Back-to-back single-cycle ops therefore issue every 2 cycles.
- in_valid asserted while in_ready=0 has no effect. The requester must hold the request until it is accepted.
- out_ready low in DONE stalls indefinitely with all outputs stable.
- out_ready high outside DONE has no effect.

## Test plan
- ADD with A=0xFF, B=0x01 → after 1 edge: alu_out=0x00, carry_out=1, zero=1, overflow=0. SUB with A=0x80, B=0x01 → alu_out=0x7F, overflow=1, carry_out=0. SUB with A=0x10, B=0x20 → alu_out=0xF0, carry_out=1.
- MUL with A=0xFF, B=0xFF → out_valid exactly 9 edges after accept; alu_out=0x01, alu_out_hi=0xFE; in_ready=0 throughout.
- DIV with A=200, B=7 → after 9 edges: alu_out=0x1C, alu_out_hi=0x04. DIV with A=0x55, B=0 → after 1 edge: alu_out=0xFF, alu_out_hi=0x55, div_by_zero=1.
- ROL with A=0x81, B=3 → 0x0C. ROR with A=0x81, B=1 → 0xC0. SHL with A=0x81, B=8 (amount 0) → 0x81. GT with A=0x80, B=0x7F → 0x01.
- Backpressure: hold out_ready=0 for 5 cycles after a result and toggle in_valid/inputs meanwhile → outputs unchanged and no accept. Raising out_ready → in_ready=1 on the next cycle and the new op is accepted.
- Assert rst asynchronously at the 4th EXEC cycle of a DIV → all outputs 0 immediately. After release, ADD 0x03+0x04 → alu_out=0x07 after 1 edge, and no stale DIV result ever appears.
